// File: rtl/pwm_update_ctrl.sv
// pwm_update_ctrl: shadow/commit sequencer in front of the 1-bit PWM.
// New period/duty land at a period boundary or behind a fixed hold.
module pwm_update_ctrl #(
    parameter int unsigned HOLD_CYCLES  = 4,
    parameter logic [31:0] DEFAULT_FREQ = 32'd75000,
    parameter logic [31:0] DEFAULT_DUTY = 32'd37500
) (
    input  logic        xclk,
    input  logic        reset,
    input  logic        wr_strobe,
    input  logic [2:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic [31:0] stored_pwm_freq,
    output logic [31:0] stored_pwm_dty_cycl,
    output logic        pwm_reset,
    output logic        busy,
    output logic        update_done,
    output logic        cfg_error,
    output logic        commit_overrun
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_END = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t      state, state_d;
    logic [31:0] shadow_freq, shadow_duty;
    logic [31:0] staged_freq, staged_duty;
    logic [31:0] act_freq_d, act_duty_d;
    logic [31:0] mirror;
    logic [7:0]  hold_cnt, hold_cnt_d;
    logic        enable, enable_d;
    logic        load_stage, done_d, err_d, ovr_d;
    logic        wr_commit, cfg_ok, period_end, hold_last;

    assign wr_commit  = wr_strobe && (wr_addr == 3'd4);
    assign cfg_ok     = (shadow_freq != 32'd0) &&
                        (shadow_duty <= shadow_freq);
    assign period_end = (mirror == stored_pwm_freq) && pwm_reset;
    assign hold_last  = (hold_cnt == 8'(HOLD_CYCLES - 1));

    // Next-state, completion and flag logic of the update sequencer.
    always_comb begin
        state_d    = state;
        hold_cnt_d = hold_cnt;
        act_freq_d = stored_pwm_freq;
        act_duty_d = stored_pwm_dty_cycl;
        enable_d   = enable;
        load_stage = 1'b0;
        done_d     = 1'b0;
        err_d      = cfg_error;
        ovr_d      = commit_overrun;
        if (wr_strobe && (wr_addr == 3'd5)) begin
            enable_d = wr_data[0];
        end
        if (wr_strobe && (wr_addr == 3'd6)) begin
            ovr_d = 1'b0;
        end
        unique case (state)
            IDLE: begin
                if (wr_commit) begin
                    if (cfg_ok) begin
                        err_d      = 1'b0;
                        load_stage = 1'b1;
                        if (wr_data[0]) begin
                            state_d = WAIT_END;
                        end else begin
                            state_d    = HOLD;
                            hold_cnt_d = 8'd0;
                            act_freq_d = shadow_freq;
                            act_duty_d = shadow_duty;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT_END: begin
                if (wr_commit) begin
                    ovr_d = 1'b1;
                end
                if (period_end || !enable) begin
                    act_freq_d = staged_freq;
                    act_duty_d = staged_duty;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            HOLD: begin
                if (wr_commit) begin
                    ovr_d = 1'b1;
                end
                if (hold_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shadow registers take bus writes in any state.
    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            shadow_freq <= DEFAULT_FREQ;
            shadow_duty <= DEFAULT_DUTY;
        end else if (wr_strobe) begin
            case (wr_addr)
                3'd0: shadow_freq[15:0]  <= wr_data;
                3'd1: shadow_freq[31:16] <= wr_data;
                3'd2: shadow_duty[15:0]  <= wr_data;
                3'd3: shadow_duty[31:16] <= wr_data;
                default: ;
            endcase
        end
    end

    // Staged copy freezes the committed values against later writes.
    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            staged_freq <= DEFAULT_FREQ;
            staged_duty <= DEFAULT_DUTY;
        end else if (load_stage) begin
            staged_freq <= shadow_freq;
            staged_duty <= shadow_duty;
        end
    end

    // State, active values and registered status outputs.
    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            hold_cnt            <= 8'd0;
            enable              <= 1'b0;
            stored_pwm_freq     <= DEFAULT_FREQ;
            stored_pwm_dty_cycl <= DEFAULT_DUTY;
            pwm_reset           <= 1'b0;
            busy                <= 1'b0;
            update_done         <= 1'b0;
            cfg_error           <= 1'b0;
            commit_overrun      <= 1'b0;
        end else begin
            state               <= state_d;
            hold_cnt            <= hold_cnt_d;
            enable              <= enable_d;
            stored_pwm_freq     <= act_freq_d;
            stored_pwm_dty_cycl <= act_duty_d;
            pwm_reset           <= enable_d && (state_d != HOLD);
            busy                <= (state_d != IDLE);
            update_done         <= done_d;
            cfg_error           <= err_d;
            commit_overrun      <= ovr_d;
        end
    end

    // Mirror of the PWM period counter, used to find the period end.
    always_ff @(posedge xclk or posedge reset) begin
        if (reset) begin
            mirror <= 32'd0;
        end else if (!pwm_reset) begin
            mirror <= 32'd0;
        end else if (mirror == stored_pwm_freq) begin
            mirror <= 32'd0;
        end else begin
            mirror <= mirror + 32'd1;
        end
    end

endmodule

// File: tb/tb_pwm_update_ctrl.sv
// tb_pwm_update_ctrl: scoreboard bench for pwm_update_ctrl.
// Expected completions are queued at commit and checked on update_done.
module tb_pwm_update_ctrl;

    localparam int HOLD = 4;

    logic        xclk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_strobe = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [15:0] wr_data = 16'd0;
    logic [31:0] stored_pwm_freq, stored_pwm_dty_cycl;
    logic        pwm_reset, busy, update_done, cfg_error, commit_overrun;

    pwm_update_ctrl #(
        .HOLD_CYCLES (HOLD),
        .DEFAULT_FREQ(32'd75000),
        .DEFAULT_DUTY(32'd37500)
    ) dut (
        .xclk               (xclk),
        .reset              (reset),
        .wr_strobe          (wr_strobe),
        .wr_addr            (wr_addr),
        .wr_data            (wr_data),
        .stored_pwm_freq    (stored_pwm_freq),
        .stored_pwm_dty_cycl(stored_pwm_dty_cycl),
        .pwm_reset          (pwm_reset),
        .busy               (busy),
        .update_done        (update_done),
        .cfg_error          (cfg_error),
        .commit_overrun     (commit_overrun)
    );

    always #5 xclk = ~xclk;

    longint cyc = 0;
    always @(posedge xclk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] f;
        logic [31:0] d;
        longint      at;
    } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [31:0] m_sf, m_sd, m_af, m_ad;
    bit          m_en, m_err, m_ovr, m_acc;
    longint      m_epoch, m_done;

    function automatic void chk(input string n,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     n, act, exp, cyc);
        end
    endfunction

    function automatic void model_reset();
        m_sf = 32'd75000; m_sd = 32'd37500;
        m_af = 32'd75000; m_ad = 32'd37500;
        m_en = 0; m_err = 0; m_ovr = 0; m_acc = 0;
        m_epoch = 0; m_done = 0;
        sb.delete();
    endfunction

    // A commit in cycle c: validity, then the cycle the new values land.
    function automatic void do_commit(input longint c, input bit sync);
        longint k;
        m_acc = 0;
        if (c < m_done) begin
            m_ovr = 1;
        end else if (m_sf == 0 || m_sd > m_sf) begin
            m_err = 1;
        end else begin
            m_err = 0;
            m_acc = 1;
            if (!sync) begin
                m_done  = c + 1 + HOLD;
                m_epoch = m_done;
            end else if (!m_en) begin
                m_done = c + 2;
            end else begin
                k = (c + 1 - m_epoch) % (longint'(m_af) + 1);
                m_done  = c + 2 + longint'(m_af) - k;
                m_epoch = m_done;
            end
            m_af = m_sf;
            m_ad = m_sd;
            sb.push_back('{m_sf, m_sd, m_done});
        end
    endfunction

    // Called at a falling edge; drives one strobe cycle.
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        longint c;
        c = cyc;
        wr_strobe = 1'b1;
        wr_addr   = a;
        wr_data   = d;
        case (a)
            3'd0: m_sf[15:0]  = d;
            3'd1: m_sf[31:16] = d;
            3'd2: m_sd[15:0]  = d;
            3'd3: m_sd[31:16] = d;
            3'd4: do_commit(c, d[0]);
            3'd5: begin
                if (d[0] && !m_en) m_epoch = c + 1;
                m_en = d[0];
            end
            3'd6: m_ovr = 0;
            default: ;
        endcase
        @(negedge xclk);
        wr_strobe = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (cyc < m_done && n < limit) begin
            @(negedge xclk);
            n++;
        end
        chk("idle_reached", cyc >= m_done, 1);
    endtask

    // Entered one cycle after an accepted immediate commit.
    task automatic hold_check();
        for (int i = 0; i < HOLD; i++) begin
            chk("hold_low", pwm_reset, 0);
            @(negedge xclk);
        end
        chk("hold_release", pwm_reset, m_en);
    endtask

    // Monitor: every update_done pops one expected completion.
    always @(negedge xclk) begin
        if (!reset && update_done) begin
            chk("done_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("done_freq", stored_pwm_freq, e.f);
                chk("done_duty", stored_pwm_dty_cycl, e.d);
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        int n;
        bit low;
        bit en, sync;
        logic [31:0] f, d;
        model_reset();
        repeat (3) @(negedge xclk);
        chk("rst_freq", stored_pwm_freq, 75000);
        chk("rst_duty", stored_pwm_dty_cycl, 37500);
        chk("rst_pwm_reset", pwm_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", update_done, 0);
        chk("rst_err", cfg_error, 0);
        chk("rst_ovr", commit_overrun, 0);
        reset = 1'b0;
        @(negedge xclk);
        chk("pre_en_pwm_reset", pwm_reset, 0);
        wr(3'd5, 16'd1);
        chk("en_pwm_reset", pwm_reset, 1);

        // boundary update at mirror = 10 of a default period
        wr(3'd0, 16'd100); wr(3'd1, 16'd0);
        wr(3'd2, 16'd40);  wr(3'd3, 16'd0);
        while (cyc < m_epoch + 10) @(negedge xclk);
        wr(3'd4, 16'd1);
        n = 0;
        low = 0;
        while (busy && n < 80000) begin
            if (!pwm_reset) low = 1;
            n++;
            @(negedge xclk);
        end
        chk("sync_busy_len", n, 74990);
        chk("sync_pwm_reset_low", low, 0);
        chk("sync_freq", stored_pwm_freq, 100);
        chk("sync_duty", stored_pwm_dty_cycl, 40);

        // immediate update
        wr(3'd0, 16'd20); wr(3'd2, 16'd5);
        wr(3'd4, 16'd0);
        chk("imm_freq", stored_pwm_freq, 20);
        chk("imm_duty", stored_pwm_dty_cycl, 5);
        hold_check();
        wait_idle(50);

        // rejected commits, then a clearing one
        wr(3'd2, 16'd30);
        wr(3'd4, 16'd0);
        chk("bad_duty_err", cfg_error, 1);
        chk("bad_duty_busy", busy, 0);
        chk("bad_duty_freq", stored_pwm_freq, 20);
        @(negedge xclk);
        chk("bad_duty_busy2", busy, 0);
        wr(3'd0, 16'd0);
        wr(3'd4, 16'd1);
        chk("zero_freq_err", cfg_error, 1);
        chk("zero_freq_busy", busy, 0);
        wr(3'd0, 16'd20); wr(3'd2, 16'd10);
        wr(3'd4, 16'd1);
        chk("good_err", cfg_error, 0);
        chk("good_busy", busy, 1);
        wait_idle(200);

        // overrun during a pending boundary update
        wr(3'd0, 16'd50); wr(3'd2, 16'd25);
        n = 0;
        while ((cyc - m_epoch) % (longint'(m_af) + 1) != 2 && n < 100) begin
            @(negedge xclk);
            n++;
        end
        wr(3'd4, 16'd1);
        wr(3'd0, 16'd7);
        wr(3'd4, 16'd1);
        chk("ovr_set", commit_overrun, m_ovr);
        wait_idle(200);
        chk("ovr_sticky", commit_overrun, m_ovr);
        chk("ovr_freq", stored_pwm_freq, 50);
        chk("ovr_duty", stored_pwm_dty_cycl, 25);
        wr(3'd6, 16'd0);
        chk("ovr_clear", commit_overrun, 0);

        // reset in the middle of a hold
        wr(3'd0, 16'd30); wr(3'd2, 16'd3);
        wr(3'd4, 16'd0);
        @(negedge xclk);
        reset = 1'b1;
        #1;
        chk("arst_freq", stored_pwm_freq, 75000);
        chk("arst_duty", stored_pwm_dty_cycl, 37500);
        chk("arst_pwm_reset", pwm_reset, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", cfg_error, 0);
        model_reset();
        repeat (2) @(negedge xclk);
        reset = 1'b0;
        @(negedge xclk);
        wr(3'd5, 16'd1);
        repeat (40) @(negedge xclk);
        chk("post_rst_freq", stored_pwm_freq, 75000);
        chk("post_rst_busy", busy, 0);

        // upper halves: default freq hi = 1 stays
        wr(3'd0, 16'd16); wr(3'd2, 16'd0); wr(3'd3, 16'd1);
        wr(3'd4, 16'd0);
        chk("hi_freq", stored_pwm_freq, 32'h0001_0010);
        chk("hi_duty", stored_pwm_dty_cycl, 32'h0001_0000);
        hold_check();
        wr(3'd3, 16'd2);
        wr(3'd4, 16'd0);
        chk("hi_bad_err", cfg_error, 1);
        wr(3'd1, 16'd0); wr(3'd3, 16'd0);
        wr(3'd4, 16'd0);
        hold_check();
        chk("lo_freq", stored_pwm_freq, 16);

        // randomized commits against the model
        for (int it = 0; it < 25; it++) begin
            en = ($urandom_range(0, 3) != 0);
            if (en != m_en) begin
                wr(3'd5, {15'd0, en});
                chk("rnd_enable", pwm_reset, en);
            end
            f = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(1, 60);
            d = $urandom_range(0, f + 4);
            wr(3'd0, f[15:0]); wr(3'd1, 16'd0);
            wr(3'd2, d[15:0]); wr(3'd3, 16'd0);
            sync = $urandom_range(0, 1);
            wr(3'd4, {15'd0, sync});
            chk("rnd_err", cfg_error, m_err);
            chk("rnd_busy", busy, cyc < m_done);
            if (m_acc && !sync) hold_check();
            else wait_idle(300);
            chk("rnd_freq", stored_pwm_freq, m_af);
            chk("rnd_duty", stored_pwm_dty_cycl, m_ad);
            repeat ($urandom_range(0, 3)) @(negedge xclk);
        end

        repeat (5) @(negedge xclk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pwm_update_ctrl.md
Name: pwm_update_ctrl

Overview:
- Configuration sequencer for the 1-bit PWM generator.
- Accepts 16-bit DSP bus writes into shadow period/duty registers and validates them on a commit.
- Drives the PWM's stored_pwm_freq, stored_pwm_dty_cycl and active-low pwm_reset so that new settings are applied either glitch-free at a period boundary or immediately with a controlled hold.
- Sits between the DSP bus decode and the PWM instance.

Parameters:
- HOLD_CYCLES, 4: cycles pwm_reset is held low on an immediate update. Legal range 1..255.
- DEFAULT_FREQ, 32'd75000: reset value of shadow and active period (1 kHz at 75 MHz).
- DEFAULT_DUTY, 32'd37500: reset value of shadow and active duty (50%).

Ports:
- xclk  in  1  system clock, 75 MHz.
- reset  in  1  asynchronous, active-high reset.
- wr_strobe  in  1  single-cycle bus write qualifier.
- wr_addr  in  3  register select.
- wr_data  in  16  write data.
- stored_pwm_freq  out  32  active period count to PWM.
- stored_pwm_dty_cycl  out  32  active duty count to PWM.
- pwm_reset  out  1  low holds the PWM counter and output at 0.
- busy  out  1  high while an update is pending or holding.
- update_done  out  1  one-cycle pulse when new values are active.
- cfg_error  out  1  last commit was rejected.
- commit_overrun  out  1  sticky: a commit arrived while busy.

Behaviour:
- Reset (asynchronous, active-high):
  - shadow and active regs = DEFAULT_FREQ / DEFAULT_DUTY.
  - enable = 0, so pwm_reset = 0.
  - busy = update_done = cfg_error = commit_overrun = 0.
  - state = IDLE, mirror counter = 0.
- Register map, decoded on wr_strobe:
  - 0 freq[15:0], 1 freq[31:16], 2 duty[15:0], 3 duty[31:16] (shadow registers; writable in any state).
  - 4 commit: wr_data[0] = 1 selects sync mode, 0 selects immediate mode.
  - 5 enable = wr_data[0].
  - 6 clears commit_overrun.
  - 7 no effect.
- Mirror counter, 32-bit, replicates the PWM's counter exactly:
  - cleared while pwm_reset = 0;
  - otherwise goes to 0 when equal to active freq, else increments.
  - period_end = (mirror == active freq) && pwm_reset.
- Validation at commit: valid iff shadow freq != 0 and shadow duty <= shadow freq.
  - Invalid: cfg_error = 1, state stays IDLE, active regs unchanged.
  - Valid: cfg_error = 0 and shadow is copied into staged regs on the commit cycle. Later shadow writes do not affect the pending update.
- States:
  - IDLE: a valid commit with sync=1 goes to WAIT_END; with sync=0 goes to HOLD. busy rises the cycle after the commit.
  - WAIT_END: on the period_end cycle, copy staged into active, pulse update_done, return to IDLE. No hold is needed: the PWM sees counter = 0 against the new values on the next cycle.
    - If enable = 0 (PWM already held), apply immediately on the next cycle with the same completion actions.
  - HOLD: pwm_reset = 0 for exactly HOLD_CYCLES cycles. Active regs are loaded on the first HOLD cycle. Then return to IDLE, release pwm_reset (if enable = 1) and pulse update_done the same cycle.
- pwm_reset = enable && (state != HOLD). The output is registered.
- A commit while busy is ignored and sets commit_overrun; shadow is unaffected.
- A write to addr 5 during HOLD takes effect after HOLD ends; the hold is never shortened.
- A simultaneous commit and addr-6 write cannot occur (single address per strobe).
- Reset mid-update aborts to the reset state; the staged values are lost.
- A 32-bit write is non-atomic by design; only the commit applies it.

Test Plan:
- Reset, then enable=1: stored_pwm_freq = 75000, stored_pwm_dty_cycl = 37500, pwm_reset rises one cycle after the write; the mirror counter wraps every 75001 clocks.
- Write freq = 100, duty = 40, commit sync=1 while mirror = 10 -> active regs change and update_done pulses on the cycle mirror == 75000; pwm_reset stays 1 throughout; busy high for 74990 cycles.
- Write freq = 20, duty = 5, commit sync=0 -> pwm_reset low for exactly 4 cycles starting the cycle after the commit; active = 20/5 from the first low cycle; update_done coincides with the release.
- Commit with duty = 30, freq = 20, and separately with freq = 0 -> cfg_error = 1, active regs unchanged, busy never rises. A following valid commit clears cfg_error.
- Second commit during WAIT_END -> ignored, commit_overrun = 1 until an addr-6 write; the first update completes with its originally staged values even though shadow freq was rewritten after the first commit.
- Assert reset during HOLD -> all outputs return to reset values asynchronously; after release, the old staged values are never applied.
